vga_scan_gen: RTL and testbench
===============================

# vga_scan_gen

Parametrised VGA scan generator that replaces the fixed QVGA timing block. Generates horizontal and vertical sync and data-enable from per-axis timing parameters. Fetches pixels from the video buffer through a single-cycle-latency read port and drives RGB outputs aligned to the syncs. Sits between the frame buffer and the board VGA connector, clocked by the pixel clock.

## Interface
- H_ACTIVE, 320: visible pixels per line
- H_FP, 16 / H_SYNC, 24 / H_BP, 40: horizontal front porch / sync / back porch, in pixels
- V_ACTIVE, 240: visible lines per frame
- V_FP, 5 / V_SYNC, 2 / V_BP, 13: vertical porches and sync, in lines
- HS_POL, 0 / VS_POL, 0: sync active level (0 = active-low)
- COLOR_BITS, 4: bits per colour channel
- ADDR_W, 17: read address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE
- Clocking and reset: one clock; reset is asynchronous and active-high.
- pclk  in  1  pixel clock, the only clock
- rst  in  1  asynchronous active-high reset
- en  in  1  scan enable
- r_data  in  3*COLOR_BITS  pixel {R,G,B}, valid when r_dv is high
- r_dv  in  1  read data valid, returned exactly 1 cycle after r_en
- r_clk  out  1  equals pclk
- r_addr  out  ADDR_W  linear pixel address
- r_en  out  1  read strobe
- red_bits / green_bits / blue_bits  out  COLOR_BITS each  colour outputs
- hsync, vsync  out  1  syncs, polarity set by HS_POL/VS_POL
- de  out  1  active video, aligned with the colour outputs
- frame_start  out  1  one-cycle pulse coinciding with the first active pixel of a frame on the outputs
- underrun  out  1  sticky flag: an active pixel arrived without r_dv

## Operation
- Each axis has its own state machine: ACTV -> FP -> SYNC -> BP -> ACTV. Each state runs for its parameter count, 0..N-1.
- The horizontal counter advances every cycle while en is high.
- The vertical axis advances once per line, on the last BP cycle of the horizontal axis.
- Sync is asserted only in SYNC state. Stage-0 active = (h ACTV) AND (v ACTV).
- r_en = stage-0 active. r_addr starts at 0 on the first active pixel of a frame and increments by 1 after each active pixel.
- r_addr returns to 0 at frame start. It is never derived from a multiply.
- Stage 1 is the read-return cycle. Stage 2 registers the outputs: syncs, de, colours.
- If de is high and r_dv is low at stage 1, the colour outputs are 0 and underrun is set. underrun clears only on rst.
- Colours are forced to 0 whenever de is low.
- en low: counters are synchronously cleared to h=0, v=0 (ACTV/ACTV) and held there. r_en stays low, and the pipeline drains to the blank, sync-inactive state within 2 cycles.
- en rising: the scan begins at the first active pixel of a frame.
- Counter widths come from $clog2 of each axis total. No overflow is possible.

## Timing
- Reset values:
  - syncs inactive (hsync = ~HS_POL, vsync = ~VS_POL)
  - de, frame_start, underrun, r_en = 0
  - r_addr = 0, colours = 0
  - states ACTV/ACTV, counters 0
- Latency: counter state to pins is 2 cycles. hsync, vsync, de and colours are mutually aligned on every cycle.
- Line period is H_ACTIVE+H_FP+H_SYNC+H_BP = 400 cycles. Frame period is 260 lines = 104000 cycles (60.1 Hz at 6.25 MHz).
- End of line and end of frame in the same cycle: both axes wrap together, and the next cycle is h=0, v=0 with r_en high.
- rst mid-line: all outputs take their reset values immediately (asynchronously). After release, the scan restarts at frame start.

## Configuration
- VGA_TEST_PATTERN_EN defined:
  - adds input pattern_sel (1 bit)
  - while pattern_sel is high, colours come from an 8-bar generator (bar = h_count*8/H_ACTIVE; colour bits {R,G,B} = bar[2:0], each bit expanded to all ones)
  - r_en is held low while pattern_sel is high, and underrun is not updated
  - pattern_sel is sampled at frame start only
- VGA_TEST_PATTERN_EN undefined: pattern_sel and the bar generator are absent, and the block always displays buffer data.

## Structure
- Shared package vga_pkg holds:
  - typedef enum scan_state_t {ACTV, FP, SYNC, BP}
  - default QVGA timing localparams
  - a function returning the axis total
- Sub-module vga_axis_counter (parameters ACTIVE, FP, SYNC, BP) holds one axis state machine and counter.
  - ports: step, clear, state, count, wrap
  - instantiated twice: horizontal step = en; vertical step = horizontal wrap

## Test plan
- Default parameters, en high, r_dv echoes r_en delayed by one cycle -> hsync low for exactly 24 cycles every 400; vsync low for 2 lines (800 cycles) every 104000; de high for 320 cycles per line on 240 lines.
- Buffer returns r_data = low 12 bits of r_addr -> output colour at the first de cycle of line 1 is 320; the last pixel of a frame shows 76799 mod 4096; r_addr wraps to 0.
- r_dv forced low for one cycle at pixel 10 of line 0 -> that pixel outputs 0, underrun rises and stays high for the next frame.
- rst asserted at h=150, v=100, then released -> outputs at reset values within the same cycle; the first de after release has r_addr 0 and frame_start high.
- en dropped mid-frame for 50 cycles, then raised -> no sync pulses while low; 2 cycles after the rise, de is high with frame_start.
- Build with VGA_TEST_PATTERN_EN and pattern_sel=1 -> pixels 0..39 are black and pixels 280..319 are white (4'hF on each channel); r_en is never asserted.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: scan-state type, default QVGA timing and the axis-length helper
// shared by the VGA scan generator and its axis counters.
package vga_pkg;

    typedef enum logic [1:0] {ACTV, FP, SYNC, BP} scan_state_t;

    localparam int QVGA_H_ACTIVE = 320;
    localparam int QVGA_H_FP     = 16;
    localparam int QVGA_H_SYNC   = 24;
    localparam int QVGA_H_BP     = 40;
    localparam int QVGA_V_ACTIVE = 240;
    localparam int QVGA_V_FP     = 5;
    localparam int QVGA_V_SYNC   = 2;
    localparam int QVGA_V_BP     = 13;

    function automatic int axis_total(input int active, input int fp,
                                      input int sync_len, input int bp);
        return active + fp + sync_len + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one scan axis, ACTV -> FP -> SYNC -> BP, each state
// counting 0..len-1. wrap pulses on the step that leaves the last BP cycle.
module vga_axis_counter
    import vga_pkg::scan_state_t;
    import vga_pkg::axis_total;
#(
    parameter  int ACTIVE = 320,
    parameter  int FP     = 16,
    parameter  int SYNC   = 24,
    parameter  int BP     = 40,
    localparam int CW     = $clog2(axis_total(ACTIVE, FP, SYNC, BP))
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic          step,
    input  logic          clear,
    output scan_state_t   state,
    output logic [CW-1:0] count,
    output logic          wrap
);

    int   len;
    logic last;

    function automatic scan_state_t next_state(input scan_state_t s);
        case (s)
            vga_pkg::ACTV: return vga_pkg::FP;
            vga_pkg::FP:   return vga_pkg::SYNC;
            vga_pkg::SYNC: return vga_pkg::BP;
            default:       return vga_pkg::ACTV;
        endcase
    endfunction

    // NOTE: every signal driven from always_comb gets a default first, so no latch is inferred.
    always_comb begin
        len = ACTIVE;
        case (state)
            vga_pkg::FP:   len = FP;
            vga_pkg::SYNC: len = SYNC;
            vga_pkg::BP:   len = BP;
            default:       len = ACTIVE;
        endcase
        last = (count == CW'(len - 1));
    end

    assign wrap = step && !clear && (state == vga_pkg::BP) && last;

    // NOTE: state is updated with non-blocking assignments so the other axis sees pre-edge values.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state <= vga_pkg::ACTV;
            count <= '0;
        end else if (clear) begin
            state <= vga_pkg::ACTV;
            count <= '0;
        end else if (step) begin
            if (last) begin
                state <= next_state(state);
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/vga_scan_gen.sv
// vga_scan_gen: parametrised VGA syncs and pixel fetch, counters -> read -> pins
// in two cycles. Define VGA_TEST_PATTERN_EN to add the 8-bar test pattern.
module vga_scan_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = QVGA_H_ACTIVE,
    parameter int H_FP       = QVGA_H_FP,
    parameter int H_SYNC     = QVGA_H_SYNC,
    parameter int H_BP       = QVGA_H_BP,
    parameter int V_ACTIVE   = QVGA_V_ACTIVE,
    parameter int V_FP       = QVGA_V_FP,
    parameter int V_SYNC     = QVGA_V_SYNC,
    parameter int V_BP       = QVGA_V_BP,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int COLOR_BITS = 4,
    parameter int ADDR_W     = 17
) (
    input  logic                    pclk,
    input  logic                    rst,
    input  logic                    en,
`ifdef VGA_TEST_PATTERN_EN
    input  logic                    pattern_sel,
`endif
    input  logic [3*COLOR_BITS-1:0] r_data,
    input  logic                    r_dv,
    output logic                    r_clk,
    output logic [ADDR_W-1:0]       r_addr,
    output logic                    r_en,
    output logic [COLOR_BITS-1:0]   red_bits,
    output logic [COLOR_BITS-1:0]   green_bits,
    output logic [COLOR_BITS-1:0]   blue_bits,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    de,
    output logic                    frame_start,
    output logic                    underrun
);

    localparam int HW  = $clog2(axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
    localparam int VW  = $clog2(axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
    localparam int RGB = 3 * COLOR_BITS;

    scan_state_t       h_state, v_state;
    logic [HW-1:0]     h_count;
    logic [VW-1:0]     v_count;
    logic              h_wrap, v_wrap;

    logic              act0, first0, pat0;
    logic [ADDR_W-1:0] addr_q;
    logic              s1_de, s1_hs, s1_vs, s1_first, s1_pat;
    logic [RGB-1:0]    bar_rgb, rgb_next;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
    ) u_h_axis (
        .pclk (pclk),
        .rst  (rst),
        .step (en),
        .clear(!en),
        .state(h_state),
        .count(h_count),
        .wrap (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
    ) u_v_axis (
        .pclk (pclk),
        .rst  (rst),
        .step (h_wrap),
        .clear(!en),
        .state(v_state),
        .count(v_count),
        .wrap (v_wrap)
    );

    assign act0   = en && (h_state == ACTV) && (v_state == ACTV);
    assign first0 = act0 && (h_count == '0) && (v_count == '0);

    // The strobe drops with rst itself so the read port is quiet during reset.
    assign r_en   = act0 && !pat0 && !rst;
    assign r_addr = addr_q;
    assign r_clk  = pclk;

`ifdef VGA_TEST_PATTERN_EN
    logic       pat_q;
    logic [2:0] bar0, s1_bar;

    assign pat0    = first0 ? pattern_sel : pat_q;
    assign bar0    = 3'((32'(h_count) * 32'd8) / 32'(H_ACTIVE));
    assign bar_rgb = {{COLOR_BITS{s1_bar[2]}}, {COLOR_BITS{s1_bar[1]}}, {COLOR_BITS{s1_bar[0]}}};

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            pat_q  <= 1'b0;
            s1_pat <= 1'b0;
            s1_bar <= '0;
        end else begin
            pat_q  <= pat0;
            s1_pat <= pat0;
            s1_bar <= bar0;
        end
    end
`else
    assign pat0    = 1'b0;
    assign s1_pat  = 1'b0;
    assign bar_rgb = '0;
`endif

    // Stage 0 -> 1: linear address counts active pixels, reset at frame wrap.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            s1_de    <= 1'b0;
            s1_hs    <= 1'b0;
            s1_vs    <= 1'b0;
            s1_first <= 1'b0;
        end else begin
            if (!en || v_wrap) begin
                addr_q <= '0;
            end else if (act0) begin
                addr_q <= addr_q + ADDR_W'(1);
            end
            s1_de    <= act0;
            s1_hs    <= en && (h_state == SYNC);
            s1_vs    <= en && (v_state == SYNC);
            s1_first <= first0;
        end
    end

    always_comb begin
        rgb_next = '0;
        if (s1_de) begin
            if (s1_pat) begin
                rgb_next = bar_rgb;
            end else if (r_dv) begin
                rgb_next = r_data;
            end
        end
    end

    // Stage 1 -> 2: pins, all registered together so they stay aligned.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            de          <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            red_bits    <= '0;
            green_bits  <= '0;
            blue_bits   <= '0;
        end else begin
            hsync       <= s1_hs ? HS_POL : ~HS_POL;
            vsync       <= s1_vs ? VS_POL : ~VS_POL;
            de          <= s1_de;
            frame_start <= s1_first;
            underrun    <= underrun | (s1_de && !s1_pat && !r_dv);
            {red_bits, green_bits, blue_bits} <= rgb_next;
        end
    end

endmodule

// File: tb/tb_vga_scan_gen.sv
// tb_vga_scan_gen: randomized en/rst/r_dv stimulus, expected pins from a
// position-based model pushed into scoreboard queues and popped by a monitor.
module tb_vga_scan_gen;

    localparam int HA    = 16;
    localparam int HFP   = 2;
    localparam int HSY   = 3;
    localparam int HBP   = 4;
    localparam int VA    = 6;
    localparam int VFP   = 1;
    localparam int VSY   = 2;
    localparam int VBP   = 2;
    localparam bit HPOL  = 1'b1;
    localparam bit VPOL  = 1'b0;
    localparam int LINE  = HA + HFP + HSY + HBP;
    localparam int NLINE = VA + VFP + VSY + VBP;
    localparam int FRAME = LINE * NLINE;
    localparam int N_CYC = 4000;

    logic        pclk = 1'b0;
    logic        rst, en, r_dv;
    logic [11:0] r_data;
    logic        r_clk, r_en;
    logic [7:0]  r_addr;
    logic [3:0]  red_bits, green_bits, blue_bits;
    logic        hsync, vsync, de, frame_start, underrun;
`ifdef VGA_TEST_PATTERN_EN
    logic        pattern_sel;
`endif

    vga_scan_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(HPOL), .VS_POL(VPOL), .COLOR_BITS(4), .ADDR_W(8)
    ) dut (
        .pclk       (pclk),
        .rst        (rst),
        .en         (en),
`ifdef VGA_TEST_PATTERN_EN
        .pattern_sel(pattern_sel),
`endif
        .r_data     (r_data),
        .r_dv       (r_dv),
        .r_clk      (r_clk),
        .r_addr     (r_addr),
        .r_en       (r_en),
        .red_bits   (red_bits),
        .green_bits (green_bits),
        .blue_bits  (blue_bits),
        .hsync      (hsync),
        .vsync      (vsync),
        .de         (de),
        .frame_start(frame_start),
        .underrun   (underrun)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        int         cyc;
        logic       hs, vs, de, fs, ur;
        logic [11:0] rgb;
    } pin_t;

    typedef struct {
        int         cyc;
        logic       ren;
        logic       chk_addr;
        logic [7:0] addr;
    } s0_t;

    pin_t pin_q[$];
    s0_t  s0_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cur_cyc = -1;
    bit   done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cur_cyc, act, exp);
        end
    endtask

    function automatic pin_t reset_pin(input int c);
        pin_t p;
        p.cyc = c;
        p.hs  = ~HPOL;
        p.vs  = ~VPOL;
        p.de  = 1'b0;
        p.fs  = 1'b0;
        p.ur  = 1'b0;
        p.rgb = '0;
        return p;
    endfunction

    // Monitor: pops one stage-0 and one pin expectation per cycle.
    s0_t  ms;
    pin_t mp;
    always @(negedge pclk) begin
        if (cur_cyc >= 0 && !done) begin
            check("r_clk", r_clk, 0);
            if (s0_q.size() == 0) begin
                check("s0_avail", 32'(s0_q.size()), 1);
            end else begin
                ms = s0_q.pop_front();
                check("s0_tag", ms.cyc, cur_cyc);
                check("r_en", r_en, ms.ren);
                if (ms.chk_addr) check("r_addr", r_addr, ms.addr);
            end
            if (pin_q.size() == 0) begin
                check("pin_avail", 32'(pin_q.size()), 1);
            end else begin
                mp = pin_q.pop_front();
                check("pin_tag", mp.cyc, cur_cyc);
                check("hsync", hsync, mp.hs);
                check("vsync", vsync, mp.vs);
                check("de", de, mp.de);
                check("frame_start", frame_start, mp.fs);
                check("rgb", {red_bits, green_bits, blue_bits}, mp.rgb);
                check("underrun", underrun, mp.ur);
            end
        end
    end

    // Stimulus, buffer emulation and reference model.
    int          pos, line, px, rst_left, en_left;
    bit          um, pat_m, prev_rst, drop_next, buf_en, rst_c, en_c;
    bit          de0, hs0, vs0, fs0, er0;
    logic [7:0]  buf_addr, addr0;
    logic [2:0]  bar;
    logic [11:0] rgb0;
    pin_t        np;

    initial begin
        pos = 0; rst_left = 0; en_left = 0;
        um = 0; pat_m = 0; prev_rst = 1; drop_next = 0; buf_en = 0; buf_addr = '0;
        rst = 1'b1; en = 1'b0; r_dv = 1'b0; r_data = '0;
`ifdef VGA_TEST_PATTERN_EN
        pattern_sel = 1'b1;
`endif
        @(posedge pclk);
        for (int c = 0; c < N_CYC; c++) begin
            @(negedge pclk);
            buf_en   = r_en;
            buf_addr = r_addr;
            @(posedge pclk);
            #1;
            cur_cyc = c;

            if (c < 2) rst_c = 1;
            else if (rst_left > 0) begin rst_c = 1; rst_left--; end
            else if (c > 600 && $urandom_range(299) == 0) begin rst_c = 1; rst_left = $urandom_range(2); end
            else rst_c = 0;

            if (en_left > 0) begin en_c = 0; en_left--; end
            else if (c > 600 && $urandom_range(249) == 0) begin en_c = 0; en_left = $urandom_range(49); end
            else en_c = 1;

            rst    = rst_c;
            en     = en_c;
            r_dv   = buf_en && !drop_next;
            r_data = 12'(buf_addr);
            drop_next = (c > 400) && ($urandom_range(39) == 0);
`ifdef VGA_TEST_PATTERN_EN
            if (c > 1200 && $urandom_range(149) == 0) pattern_sel = ~pattern_sel;
`endif

            if (rst_c) begin
                if (!prev_rst) pin_q.delete();
                pin_q.push_back(reset_pin(c));
                s0_q.push_back('{cyc: c, ren: 1'b0, chk_addr: 1'b1, addr: 8'h00});
                pos = 0; um = 0; pat_m = 0;
            end else begin
                if (prev_rst) begin
                    pin_q.push_back(reset_pin(c));
                    pin_q.push_back(reset_pin(c + 1));
                end
                if (en_c) begin
                    line = pos / LINE;
                    px   = pos % LINE;
                    de0  = (px < HA) && (line < VA);
                    hs0  = (px >= HA + HFP) && (px < HA + HFP + HSY);
                    vs0  = (line >= VA + VFP) && (line < VA + VFP + VSY);
                    fs0  = (pos == 0);
                    addr0 = 8'(line * HA + px);
`ifdef VGA_TEST_PATTERN_EN
                    if (pos == 0) pat_m = pattern_sel;
`endif
                    pos = (pos + 1) % FRAME;
                end else begin
                    px = 0; de0 = 0; hs0 = 0; vs0 = 0; fs0 = 0; addr0 = '0;
                    pos = 0;
                end
                er0 = de0 && !pat_m;
                bar = 3'(px * 8 / HA);
                if (!de0)      rgb0 = '0;
                else if (pat_m) rgb0 = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
                else if (drop_next) rgb0 = '0;
                else           rgb0 = 12'(addr0);
                if (er0 && drop_next) um = 1;

                s0_q.push_back('{cyc: c, ren: er0, chk_addr: er0, addr: addr0});
                np.cyc = c + 2;
                np.hs  = hs0 ? HPOL : ~HPOL;
                np.vs  = vs0 ? VPOL : ~VPOL;
                np.de  = de0;
                np.fs  = fs0;
                np.rgb = rgb0;
                np.ur  = um;
                pin_q.push_back(np);
            end
            prev_rst = rst_c;
        end
        @(negedge pclk);
        #1;
        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
